mul_unit_seq: RTL and testbench

- Parametrised iterative RV32M multiply functional unit for the OoO back end.
- Sits between the MUL reservation station and the CDB arbiter.
- Handles MUL/MULH/MULHSU/MULHU internally: sign handling, radix-2^BPC shift-add and fixup, so the issue side no longer sign-extends.
- Fixed latency, valid/ready on both sides, output held until the CDB accepts it, and squashed by flush.

---
 rtl/mul_unit_seq_pkg.sv | 36 +++
 rtl/mul_pp_step.sv | 22 ++
 rtl/mul_unit_seq.sv | 165 ++++++++++++++++
 tb/tb_mul_unit_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_unit_seq_pkg.sv
// Shared types and constants for the iterative RV32M multiply unit.
// Operation encoding, FSM states and the signedness decode of an op.
package mul_unit_seq_pkg;

  localparam int unsigned MUL_XLEN        = 32;
  localparam int unsigned MUL_BPC         = 4;
  localparam int unsigned MUL_CALC_CYCLES = MUL_XLEN / MUL_BPC;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_CALC = 2'b01,
    MUL_FIX  = 2'b10,
    MUL_DONE = 2'b11
  } mul_state_t;

  typedef struct packed {
    logic a_sgn;
    logic b_sgn;
  } mul_sgn_t;

  // Which operands are interpreted as signed for a given op.
  function automatic mul_sgn_t mul_decode(input mul_op_t op);
    mul_sgn_t s;
    s.a_sgn = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    s.b_sgn = (op == MUL_OP_MULH);
    return s;
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One radix-2^BPC step: adds mcand * digit, shifted into place, to the
// running double-width accumulator.
module mul_pp_step #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 4,
  parameter int unsigned SH_W = $clog2(2 * XLEN)
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   mcand_i,
  input  logic [BPC-1:0]    digit_i,
  input  logic [SH_W-1:0]   shift_i,
  output logic [2*XLEN-1:0] acc_next_c_o
);

  localparam int unsigned ACC_W = 2 * XLEN;

  logic [ACC_W-1:0] pp;

  assign pp           = ACC_W'(mcand_i) * ACC_W'(digit_i);
  assign acc_next_c_o = acc_i + (pp << shift_i);

endmodule

// File: rtl/mul_unit_seq.sv
// Iterative RV32M multiplier: magnitude shift-add over XLEN/BPC cycles,
// one sign-fixup cycle, result held until the CDB takes it.
module mul_unit_seq
  import mul_unit_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned BPC   = 4,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned ROB_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_op,
  input  logic [XLEN-1:0]  issue_a,
  input  logic [XLEN-1:0]  issue_b,
  input  logic [TAG_W-1:0] issue_pd,
  input  logic [ROB_W-1:0] issue_rob,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_pd,
  output logic [ROB_W-1:0] out_rob,
  output logic [XLEN-1:0]  out_rs1_rdata,
  output logic [XLEN-1:0]  out_rs2_rdata,
  output logic             busy
);

  localparam int unsigned ACC_W  = 2 * XLEN;
  localparam int unsigned CYCLES = XLEN / BPC;
  localparam int unsigned CNT_W  = $clog2(CYCLES + 1);
  localparam int unsigned SH_W   = $clog2(ACC_W);

  if (BPC == 0 || (XLEN % BPC) != 0) begin : g_bpc_check
    $error("mul_unit_seq: XLEN must be a non-zero multiple of BPC");
  end

  mul_state_t       state_q, state_d;
  mul_op_t          op_q, op_d;
  logic [TAG_W-1:0] pd_q, pd_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  mcand_q, mcand_d, mplier_q, mplier_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             accept_c, last_c;
  mul_sgn_t         sgn;

  assign accept_c = issue_valid && issue_ready;
  assign last_c   = (cnt_q == CNT_W'(CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MUL_IDLE;
    else        state_q <= state_d;
  end

  // Next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: if (accept_c) state_d = MUL_CALC;
        MUL_CALC: if (last_c) state_d = MUL_FIX;
        MUL_FIX:  state_d = MUL_DONE;
        MUL_DONE: if (out_ready) state_d = accept_c ? MUL_CALC : MUL_IDLE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  // Handshake outputs; a DONE result leaving this cycle frees the slot.
  always_comb begin
    issue_ready = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    busy        = (state_q != MUL_IDLE);
    out_valid   = (state_q == MUL_DONE);
    issue_ready = !flush && ((state_q == MUL_IDLE) ||
                             ((state_q == MUL_DONE) && out_ready));
  end

  mul_pp_step #(
    .XLEN (XLEN),
    .BPC  (BPC),
    .SH_W (SH_W)
  ) u_pp_step (
    .acc_i        (acc_q),
    .mcand_i      (mcand_q),
    .digit_i      (mplier_q[BPC-1:0]),
    .shift_i      (SH_W'(cnt_q * BPC)),
    .acc_next_c_o (acc_step)
  );

  // Datapath next values: operands become magnitudes, sign applied in FIX.
  always_comb begin
    op_d     = op_q;
    pd_d     = pd_q;
    rob_d    = rob_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sgn      = mul_decode(mul_op_t'(issue_op));
    if (accept_c) begin
      op_d     = mul_op_t'(issue_op);
      pd_d     = issue_pd;
      rob_d    = issue_rob;
      a_d      = issue_a;
      b_d      = issue_b;
      neg_d    = (sgn.a_sgn & issue_a[XLEN-1]) ^ (sgn.b_sgn & issue_b[XLEN-1]);
      mcand_d  = (sgn.a_sgn && issue_a[XLEN-1]) ? -issue_a : issue_a;
      mplier_d = (sgn.b_sgn && issue_b[XLEN-1]) ? -issue_b : issue_b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == MUL_CALC) begin
      acc_d    = acc_step;
      mplier_d = mplier_q >> BPC;
      cnt_d    = cnt_q + CNT_W'(1);
    end else if (state_q == MUL_FIX) begin
      acc_d    = neg_q ? -acc_q : acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MUL_OP_MUL;
      pd_q     <= '0;
      rob_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      pd_q     <= pd_d;
      rob_q    <= rob_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_data      = (op_q == MUL_OP_MUL) ? acc_q[XLEN-1:0] : acc_q[ACC_W-1:XLEN];
  assign out_pd        = pd_q;
  assign out_rob       = rob_q;
  assign out_rs1_rdata = a_q;
  assign out_rs2_rdata = b_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Scoreboard bench for mul_unit_seq: directed vectors plus a random
// phase with back-pressure and flush, checked by a forked monitor.
module tb_mul_unit_seq;
  import mul_unit_seq_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned ROB_W = 5;

  logic             clk, rst_n, flush;
  logic             issue_valid, issue_ready, out_valid, out_ready, busy;
  logic [1:0]       issue_op;
  logic [XLEN-1:0]  issue_a, issue_b, out_data, out_rs1_rdata, out_rs2_rdata;
  logic [TAG_W-1:0] issue_pd, out_pd;
  logic [ROB_W-1:0] issue_rob, out_rob;

  typedef struct {
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  pd;
    logic [4:0]  rob;
    time         t;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests, n_fail, n_acc, n_hs, n_kill;
  bit   rnd_mode;

  // {op, a, b, expected}
  logic [97:0] vecs [10] = '{
    {2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    {2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    {2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    {2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000},
    {2'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780},
    {2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
    {2'd1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
    {2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    {2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    {2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001}
  };

  mul_unit_seq #(.XLEN(XLEN), .BPC(4), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_a       (issue_a),
    .issue_b       (issue_b),
    .issue_pd      (issue_pd),
    .issue_rob     (issue_rob),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_pd        (out_pd),
    .out_rob       (out_rob),
    .out_rs1_rdata (out_rs1_rdata),
    .out_rs2_rdata (out_rs2_rdata),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // 64-bit reference: extend per signedness, keep low 64 bits of the product.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
    if (rnd_mode) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
    end
  endtask

  // Present an op until accepted; the expected response is queued at acceptance.
  task automatic do_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic [5:0] pd, input logic [4:0] rob,
                          output int tries);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    tries = 0;
    issue_valid = 1'b1;
    issue_op = op; issue_a = a; issue_b = b; issue_pd = pd; issue_rob = rob;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      if (issue_ready === 1'b1) begin
        e.data = exp; e.a = a; e.b = b; e.pd = pd; e.rob = rob; e.t = $time;
        sb_q.push_back(e);
        n_acc++;
        acc = 1'b1;
      end else begin
        tries++;
      end
      step();
    end
    issue_valid = 1'b0;
    chk("issue_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && (sb_q.size() != 0 || busy); n++) step();
    chk("drain_queue", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", {out_pd, out_rob}, 64'd0);
    chk("rst_out_rs", {out_rs1_rdata, out_rs2_rdata}, 64'd0);
  endtask

  task automatic monitor();
    logic        pv, phs;
    logic [42:0] p_tag;
    logic [63:0] p_rs;
    exp_t        e;
    pv = 1'b0; phs = 1'b0; p_tag = '0; p_rs = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; phs = 1'b0;
        continue;
      end
      if (out_valid && pv && !phs) begin
        chk("hold_data_tag", {out_data, out_pd, out_rob}, p_tag);
        chk("hold_rs", {out_rs1_rdata, out_rs2_rdata}, p_rs);
      end
      if (out_valid && !pv) begin
        chk("valid_has_op", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) chk("latency", 64'($time - sb_q[0].t), 64'd100);
      end
      if (out_valid && out_ready) begin
        n_hs++;
        chk("hs_has_op", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("echo_tag", {out_pd, out_rob}, {e.pd, e.rob});
          chk("echo_rs", {out_rs1_rdata, out_rs2_rdata}, {e.a, e.b});
        end
      end else if (flush && busy && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
        n_kill++;
      end
      pv    = out_valid;
      phs   = out_valid && out_ready;
      p_tag = {out_data, out_pd, out_rob};
      p_rs  = {out_rs1_rdata, out_rs2_rdata};
    end
  endtask

  initial begin
    int          tries, seen;
    logic [97:0] v;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] corner [5];
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    n_tests = 0; n_fail = 0; n_acc = 0; n_hs = 0; n_kill = 0; rnd_mode = 1'b0;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; issue_valid = 1'b0;
    issue_op = '0; issue_a = '0; issue_b = '0; issue_pd = '0; issue_rob = '0;
    fork
      monitor();
      begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    reset_checks();
    step();
    rst_n = 1'b1;
    step();

    // basic MUL with echo and latency
    do_issue(2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 6'h2A, 5'h13, tries);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      do_issue(v[97:96], v[95:64], v[63:32], v[31:0], 6'(i), 5'(i + 3), tries);
    end
    wait_idle();

    // back-pressure then back-to-back accept
    out_ready = 1'b0;
    do_issue(2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 6'h11, 5'h04, tries);
    for (int n = 0; n < 30 && !out_valid; n++) step();
    chk("bp_valid", 64'(out_valid), 64'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_issue_ready", 64'(issue_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    do_issue(2'd0, 32'd3, 32'd5, 32'd15, 6'h12, 5'h05, tries);
    chk("b2b_first_try", 64'(tries), 64'd0);
    wait_idle();

    // flush in the third CALC cycle with a competing issue
    do_issue(2'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 6'h20, 5'h10, tries);
    step();
    step();
    flush = 1'b1;
    issue_valid = 1'b1; issue_op = 2'd0; issue_a = 32'd6; issue_b = 32'd7;
    @(negedge clk);
    chk("flush_blocks_issue", 64'(issue_ready), 64'd0);
    step();
    flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_valid", 64'(out_valid), 64'd0);
    do_issue(2'd0, 32'd6, 32'd7, 32'd42, 6'h21, 5'h11, tries);
    chk("post_flush_first_try", 64'(tries), 64'd0);
    wait_idle();

    // asynchronous reset mid-CALC
    do_issue(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 6'h30, 5'h1F, tries);
    step();
    step();
    rst_n = 1'b0;
    n_kill += sb_q.size();
    sb_q.delete();
    reset_checks();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_valid_after_reset", 64'(seen), 64'd0);
    step();
    do_issue(2'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 6'h01, 5'h02, tries);
    wait_idle();

    // random ops with random back-pressure and flush
    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      do_issue(op, a, b, ref_mul(op, a, b), 6'($urandom), 5'($urandom), tries);
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd_mode = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("one_hs_per_op", 64'(n_hs + n_kill), 64'(n_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
